cpu15_seq_ctrl: RTL and testbench
=================================

CPU15_SEQ_CTRL -- requirements
Module: cpu15_seq_ctrl

Interface
REQ-001 The block SHALL have port CLK  in  1  single system clock; all state changes on rising edge.
REQ-002 The block SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have port RUN  in  1  level; 1 = continuous execution requested.
REQ-004 The block SHALL have port STEP  in  1  single-step request; acts on its rising edge, sampled on CLK.
REQ-005 The block SHALL have port HALT_REQ  in  1  pulse or level; requests a stop at the next instruction boundary.
REQ-006 The block SHALL have port OP_CODE  in  4  decoded opcode of the current instruction, valid from the DC phase through WB.
REQ-007 The block SHALL have port P_COUNT  in  8  program counter from exec, holding the next address during WB.
REQ-008 The block SHALL have ports BP_EN  in  1 and BP_ADDR  in  8  breakpoint enable and breakpoint address.
REQ-009 The block SHALL have ports EN_FT, EN_DC, EN_EX, EN_WB  out  1 each  registered one-hot phase enables for fetch, decode, exec and writeback.
REQ-010 The block SHALL have ports RUNNING  out  1, HALTED  out  1 and BP_HIT  out  1  status flags.
REQ-011 The block SHALL have port STOP_CAUSE  out  2  stop reason: 00 reset, 01 RUN dropped or step done, 10 HALT_REQ, 11 breakpoint.
REQ-012 The block SHALL have port INSN_CNT  out  16  count of retired instructions.

Function
REQ-013 The FSM SHALL have exactly six states: IDLE, FT, DC, EX, WB, HLT.
REQ-014 Each EN_x output SHALL be 1 exactly while the FSM is in the state of the same name, and 0 otherwise.
REQ-015 RUNNING SHALL be 1 in FT, DC, EX and WB, and 0 otherwise.
REQ-016 In IDLE, if RUN=1 the FSM SHALL go to FT in continuous mode; RUN SHALL take priority over a STEP edge in the same cycle.
REQ-017 In IDLE with RUN=0, a STEP rising edge SHALL send the FSM to FT in step mode.
REQ-018 STEP edge detection SHALL use a registered copy of STEP; edges seen outside IDLE SHALL be ignored, not queued.
REQ-019 From FT the FSM SHALL go to DC, from DC to EX, and from EX to WB, each unconditionally: 4 cycles per instruction.
REQ-020 In WB, INSN_CNT SHALL increment by 1 and wrap from 16'hFFFF to 16'h0000.
REQ-021 Stop conditions SHALL be evaluated in WB with this priority:
  - (a) OP_CODE == 4'hF (HLT instruction): go to HLT, HALTED=1.
  - (b) HALT_REQ latched: go to IDLE, STOP_CAUSE=10.
  - (c) BP_EN=1 and P_COUNT==BP_ADDR: go to IDLE, BP_HIT=1, STOP_CAUSE=11.
  - (d) step mode, or RUN=0: go to IDLE, STOP_CAUSE=01.
  - Otherwise: go to FT.
REQ-022 HALT_REQ SHALL be latched into a sticky pending flag in any cycle it is 1, including during WB.
REQ-023 The HALT_REQ pending flag SHALL clear on entry to IDLE; in IDLE, an asserted HALT_REQ SHALL block leaving IDLE.
REQ-024 The breakpoint SHALL be checked only in WB, so resuming from IDLE at a breakpoint address does not re-trigger before that instruction executes.
REQ-025 BP_HIT and STOP_CAUSE SHALL hold their values in IDLE and clear (BP_HIT=0, STOP_CAUSE=00) on the transition IDLE->FT.
REQ-026 HLT SHALL be terminal: RUN, STEP and HALT_REQ are ignored there, and only RESET_N exits it.
REQ-027 Changes of RUN during FT, DC or EX SHALL have no effect until WB.
REQ-028 Phase latency: with RUN=1 sampled at edge n, EN_FT SHALL be high for the cycle following edge n.

Reset
REQ-029 RESET_N=0 SHALL immediately, without waiting for CLK, force the following values:
  - state IDLE
  - all EN_x=0, RUNNING=0, HALTED=0, BP_HIT=0
  - STOP_CAUSE=00, INSN_CNT=0
  - HALT_REQ pending flag and STEP history register cleared
REQ-030 Reset asserted mid-instruction SHALL abort that instruction without incrementing INSN_CNT.
REQ-031 Reset release SHALL take effect at the first CLK edge after RESET_N=1.

Verification
REQ-032 The bench SHALL cover: RUN=1 held for 3 instructions with OP_CODE!=F -> EN_FT,EN_DC,EN_EX,EN_WB one-hot repeating every 4 cycles, and INSN_CNT=3 after the third WB.
REQ-033 The bench SHALL cover: RUN=0 with one STEP pulse -> exactly one FT..WB sequence, then IDLE with INSN_CNT=1 and STOP_CAUSE=01; STEP held high does not repeat.
REQ-034 The bench SHALL cover: BP_EN=1, BP_ADDR=8'h05, RUN=1, P_COUNT=05 at WB -> IDLE with BP_HIT=1 and STOP_CAUSE=11; a following STEP executes one instruction without re-hit.
REQ-035 The bench SHALL cover: OP_CODE=4'hF together with HALT_REQ=1 at WB -> HLT, HALTED=1, STOP_CAUSE unchanged; RUN and STEP then ignored until reset.
REQ-036 The bench SHALL cover: RESET_N low during EX with INSN_CNT=7 -> all outputs 0 asynchronously and INSN_CNT=0.
REQ-037 The bench SHALL cover: INSN_CNT preloaded to FFFF by running 65535 instructions, then one more WB -> INSN_CNT=0000.

Source files
------------

// File: rtl/cpu15_seq_ctrl.sv
// rtl/cpu15_seq_ctrl.sv - four-phase instruction sequencer with run/step/halt/breakpoint control
`timescale 1ns/1ps

module cpu15_seq_ctrl (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        RUN,
  input  logic        STEP,
  input  logic        HALT_REQ,
  input  logic [3:0]  OP_CODE,
  input  logic [7:0]  P_COUNT,
  input  logic        BP_EN,
  input  logic [7:0]  BP_ADDR,
  output logic        EN_FT,
  output logic        EN_DC,
  output logic        EN_EX,
  output logic        EN_WB,
  output logic        RUNNING,
  output logic        HALTED,
  output logic        BP_HIT,
  output logic [1:0]  STOP_CAUSE,
  output logic [15:0] INSN_CNT
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FT   = 3'd1;
  localparam logic [2:0] ST_DC   = 3'd2;
  localparam logic [2:0] ST_EX   = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HLT  = 3'd5;

  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_RUN   = 2'b01;
  localparam logic [1:0] CAUSE_HALT  = 2'b10;
  localparam logic [1:0] CAUSE_BP    = 2'b11;

  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0]  state_q, state_d;
  logic        step_q;
  logic        halt_pend_q, halt_pend_d;
  logic        step_mode_q, step_mode_d;
  logic        bp_hit_q, bp_hit_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  en_q;
  logic        running_q;
  logic        halted_q;

  logic step_edge;
  logic halt_now;
  logic bp_match;

  // STEP is only honoured as a fresh rising edge; a held level never re-triggers.
  assign step_edge = STEP & ~step_q;
  // A halt request raised in the very WB cycle still stops at this boundary.
  assign halt_now  = halt_pend_q | HALT_REQ;
  assign bp_match  = BP_EN & (P_COUNT == BP_ADDR);

  // Next-state, status and retire-counter logic.
  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    bp_hit_d    = bp_hit_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!HALT_REQ) begin
          if (RUN) begin
            state_d     = ST_FT;
            step_mode_d = 1'b0;
            bp_hit_d    = 1'b0;
            cause_d     = CAUSE_RESET;
          end else if (step_edge) begin
            state_d     = ST_FT;
            step_mode_d = 1'b1;
            bp_hit_d    = 1'b0;
            cause_d     = CAUSE_RESET;
          end
        end
      end
      ST_FT: state_d = ST_DC;
      ST_DC: state_d = ST_EX;
      ST_EX: state_d = ST_WB;
      ST_WB: begin
        cnt_d = cnt_q + 16'd1;
        if (OP_CODE == OP_HLT) begin
          state_d = ST_HLT;
        end else if (halt_now) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_HALT;
        end else if (bp_match) begin
          state_d  = ST_IDLE;
          bp_hit_d = 1'b1;
          cause_d  = CAUSE_BP;
        end else if (step_mode_q || !RUN) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_RUN;
        end else begin
          state_d = ST_FT;
        end
      end
      ST_HLT:  state_d = ST_HLT;
      default: state_d = ST_IDLE;
    endcase
    // In IDLE the live HALT_REQ level blocks the start, so nothing is kept pending there.
    halt_pend_d = (state_d == ST_IDLE) ? 1'b0 : halt_now;
  end

  // State, history and registered output flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      step_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      cause_q     <= CAUSE_RESET;
      cnt_q       <= 16'd0;
      en_q        <= 4'b0000;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= STEP;
      halt_pend_q <= halt_pend_d;
      step_mode_q <= step_mode_d;
      bp_hit_q    <= bp_hit_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      en_q        <= {state_d == ST_WB, state_d == ST_EX, state_d == ST_DC, state_d == ST_FT};
      running_q   <= (state_d == ST_FT) || (state_d == ST_DC) ||
                     (state_d == ST_EX) || (state_d == ST_WB);
      halted_q    <= (state_d == ST_HLT);
    end
  end

  assign EN_FT      = en_q[0];
  assign EN_DC      = en_q[1];
  assign EN_EX      = en_q[2];
  assign EN_WB      = en_q[3];
  assign RUNNING    = running_q;
  assign HALTED     = halted_q;
  assign BP_HIT     = bp_hit_q;
  assign STOP_CAUSE = cause_q;
  assign INSN_CNT   = cnt_q;

endmodule

// File: tb/tb_cpu15_seq_ctrl.sv
// tb/tb_cpu15_seq_ctrl.sv - self-checking bench for cpu15_seq_ctrl
`timescale 1ns/1ps

module tb_cpu15_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        RUN = 1'b0;
  logic        STEP = 1'b0;
  logic        HALT_REQ = 1'b0;
  logic [3:0]  OP_CODE = 4'h0;
  logic [7:0]  P_COUNT = 8'h00;
  logic        BP_EN = 1'b0;
  logic [7:0]  BP_ADDR = 8'h00;
  logic        EN_FT, EN_DC, EN_EX, EN_WB;
  logic        RUNNING, HALTED, BP_HIT;
  logic [1:0]  STOP_CAUSE;
  logic [15:0] INSN_CNT;

  cpu15_seq_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .HALT_REQ(HALT_REQ),
    .OP_CODE(OP_CODE), .P_COUNT(P_COUNT), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR),
    .EN_FT(EN_FT), .EN_DC(EN_DC), .EN_EX(EN_EX), .EN_WB(EN_WB),
    .RUNNING(RUNNING), .HALTED(HALTED), .BP_HIT(BP_HIT),
    .STOP_CAUSE(STOP_CAUSE), .INSN_CNT(INSN_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int n_print = 0;
  bit chk_en = 1'b0;

  // Behavioural model: busy/halted flags plus the phase index within the current instruction.
  bit          m_busy = 0, m_hlt = 0, m_stepmode = 0, m_pend = 0, m_prev = 0, m_bp = 0;
  int          m_phase = 0;
  logic [1:0]  m_cause = 2'd0;
  logic [15:0] m_cnt = 16'd0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_busy = 0; m_hlt = 0; m_stepmode = 0; m_pend = 0; m_prev = 0; m_bp = 0;
      m_phase = 0; m_cause = 2'd0; m_cnt = 16'd0;
    end else begin
      if (m_hlt) begin
        m_pend = 0;
      end else if (!m_busy) begin
        if (!HALT_REQ && (RUN || (STEP && !m_prev))) begin
          m_busy = 1; m_phase = 0; m_stepmode = !RUN; m_bp = 0; m_cause = 2'd0;
        end
      end else if (m_phase < 3) begin
        m_phase = m_phase + 1;
        m_pend = m_pend || HALT_REQ;
      end else begin
        m_cnt = m_cnt + 16'd1;
        if (OP_CODE == 4'd15) begin
          m_busy = 0; m_hlt = 1;
        end else if (m_pend || HALT_REQ) begin
          m_busy = 0; m_cause = 2'd2; m_pend = 0;
        end else if (BP_EN && P_COUNT == BP_ADDR) begin
          m_busy = 0; m_cause = 2'd3; m_bp = 1; m_pend = 0;
        end else if (m_stepmode || !RUN) begin
          m_busy = 0; m_cause = 2'd1; m_pend = 0;
        end else begin
          m_phase = 0;
        end
      end
      m_prev = STEP;
    end
  end

  logic [25:0] got_v, exp_v;
  assign got_v = {EN_WB, EN_EX, EN_DC, EN_FT, RUNNING, HALTED, BP_HIT, STOP_CAUSE, INSN_CNT};
  assign exp_v = {(m_busy ? (4'b0001 << m_phase) : 4'b0000), m_busy, m_hlt, m_bp, m_cause, m_cnt};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      n_chk++;
      if (got_v === exp_v) n_pass++;
      else if (n_print < 20) begin
        n_print++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  int run_cycles;
  bit found;
  logic [3:0] op_r;

  initial begin
    // Reset state
    cyc(3);
    chk_en = 1'b1;
    chk("reset_outputs", {6'd0, got_v}, 32'd0);
    RESET_N = 1'b1;
    cyc(2);
    chk("idle_after_release", {6'd0, got_v}, 32'd0);

    // Continuous run of three instructions; RUN drops during EX of the third
    OP_CODE = 4'h3; P_COUNT = 8'h10; RUN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk($sformatf("run_onehot_%0d", i), {28'd0, EN_WB, EN_EX, EN_DC, EN_FT}, 32'd1 << (i % 4));
      if (i == 10) RUN = 1'b0;
    end
    cyc(1);
    chk("run_cnt3", {16'd0, INSN_CNT}, 32'd3);
    chk("run_cause", {30'd0, STOP_CAUSE}, 32'd1);
    chk("run_stopped", {31'd0, RUNNING}, 32'd0);

    // Single step with STEP held high: exactly one instruction
    STEP = 1'b1;
    run_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (RUNNING) run_cycles++;
    end
    STEP = 1'b0;
    chk("step_cycles", run_cycles, 32'd4);
    chk("step_cnt", {16'd0, INSN_CNT}, 32'd4);
    chk("step_cause", {30'd0, STOP_CAUSE}, 32'd1);

    // Breakpoint hit, then a step resumes past it without re-hitting
    BP_EN = 1'b1; BP_ADDR = 8'h05; P_COUNT = 8'h05; RUN = 1'b1;
    cyc(4);
    RUN = 1'b0;
    cyc(1);
    chk("bp_hit", {31'd0, BP_HIT}, 32'd1);
    chk("bp_cause", {30'd0, STOP_CAUSE}, 32'd3);
    chk("bp_cnt", {16'd0, INSN_CNT}, 32'd5);
    cyc(2);
    chk("bp_idle_hold", {29'd0, RUNNING, BP_HIT, 1'b1}, 32'd3);
    STEP = 1'b1;
    cyc(1);
    STEP = 1'b0;
    cyc(1);
    P_COUNT = 8'h06;
    cyc(3);
    chk("bp_resume_nohit", {31'd0, BP_HIT}, 32'd0);
    chk("bp_resume_cause", {30'd0, STOP_CAUSE}, 32'd1);
    chk("bp_resume_cnt", {16'd0, INSN_CNT}, 32'd6);
    BP_EN = 1'b0;

    // HLT opcode with HALT_REQ in the same WB: HLT wins, cause stays cleared
    OP_CODE = 4'hF; RUN = 1'b1;
    cyc(4);
    HALT_REQ = 1'b1;
    cyc(1);
    HALT_REQ = 1'b0;
    chk("hlt_halted", {31'd0, HALTED}, 32'd1);
    chk("hlt_cause", {30'd0, STOP_CAUSE}, 32'd0);
    chk("hlt_cnt", {16'd0, INSN_CNT}, 32'd7);
    for (int i = 0; i < 10; i++) begin
      STEP = i[0];
      cyc(1);
    end
    STEP = 1'b0; RUN = 1'b0;
    chk("hlt_sticky", {26'd0, EN_WB, EN_EX, EN_DC, EN_FT, RUNNING, HALTED}, 32'd1);

    // Reset aborts an instruction in EX with seven retired
    RESET_N = 1'b0;
    cyc(1);
    RESET_N = 1'b1;
    OP_CODE = 4'h2; RUN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (EN_EX && INSN_CNT == 16'd7) found = 1'b1;
    end
    chk("rst_reach_ex7", {31'd0, found}, 32'd1);
    #1 RESET_N = 1'b0;
    #1 chk("rst_async_zero", {6'd0, got_v}, 32'd0);
    RUN = 1'b0;
    cyc(2);
    RESET_N = 1'b1;
    cyc(1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) RUN = ~RUN;
      STEP     = ($urandom_range(2) == 0);
      HALT_REQ = ($urandom_range(19) == 0);
      op_r     = 4'($urandom_range(15));
      if (op_r == 4'hF && $urandom_range(3) != 0) op_r = 4'h1;
      OP_CODE  = op_r;
      BP_EN    = $urandom_range(1) == 1;
      BP_ADDR  = 8'($urandom_range(3));
      P_COUNT  = 8'($urandom_range(3));
      RESET_N  = ($urandom_range(199) != 0);
      cyc(1);
    end
    RESET_N = 1'b1; RUN = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0; BP_EN = 1'b0;
    RESET_N = 1'b0;
    cyc(1);
    RESET_N = 1'b1;
    cyc(1);

    // Counter wrap: 65535 instructions, then one more
    OP_CODE = 4'h0; RUN = 1'b1;
    repeat (4 * 65535 + 1) @(negedge CLK);
    #1 chk("wrap_ffff", {16'd0, INSN_CNT}, 32'h0000FFFF);
    RUN = 1'b0;
    cyc(4);
    chk("wrap_zero", {16'd0, INSN_CNT}, 32'd0);
    chk("wrap_cause", {30'd0, STOP_CAUSE}, 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
